// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/redirect next-PC, interrupt entry/return, EPC capture.
// Latency: all outputs are registered; every PC change is visible one clock after the qualifying edge.
// Backpressure: en=0 stalls pc/epc/state; redirects and int_end are dropped during a stall, irq is latched.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   en                update enable (0 = stall/hold)
//   irq, int_end      interrupt request / interrupt return request
//   redir_valid       per-channel redirect request, index 0 has highest priority
//   redir_target      channel i target at [i*WIDTH +: WIDTH]
//   pc_out, epc_out   current PC, saved return address
//   in_handler        1 while executing the interrupt handler
//   irq_ack           one-cycle pulse in the cycle after interrupt entry
module pc_unit #(
    parameter int              WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] HANDLER_VEC = 32'h0000_4180,
    parameter int              INC         = 4,
    parameter int              NUM_REDIR   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       irq,
    input  logic                       int_end,
    input  logic [NUM_REDIR-1:0]       redir_valid,
    input  logic [NUM_REDIR*WIDTH-1:0] redir_target,
    output logic [WIDTH-1:0]           pc_out,
    output logic [WIDTH-1:0]           epc_out,
    output logic                       in_handler,
    output logic                       irq_ack
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] pc_q,      pc_d;
    logic [WIDTH-1:0] epc_q,     epc_d;
    logic             pending_q, pending_d;
    logic             irq_ack_q, irq_ack_d;

    logic [WIDTH-1:0] seq_next;
    logic             irq_req;

    // Walk from lowest to highest priority so the lowest valid index wins.
    always_comb begin
        seq_next = pc_q + INC_W;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                seq_next = redir_target[i*WIDTH +: WIDTH];
            end
        end
    end

    assign irq_req = irq | pending_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        pending_d = pending_q;
        irq_ack_d = 1'b0;

        if (en) begin
            unique case (state_q)
                ST_RUN: begin
                    // int_end has no meaning outside the handler and is ignored here.
                    if (irq_req) begin
                        epc_d     = seq_next;
                        pc_d      = HANDLER_VEC;
                        pending_d = 1'b0;
                        state_d   = ST_HANDLER;
                        irq_ack_d = 1'b1;
                    end else begin
                        pc_d = seq_next;
                    end
                end
                ST_HANDLER: begin
                    // No nesting: an irq here is only remembered and taken after return.
                    if (irq) begin
                        pending_d = 1'b1;
                    end
                    if (int_end) begin
                        pc_d    = epc_q;
                        state_d = ST_RUN;
                    end else begin
                        pc_d = seq_next;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end else if (irq) begin
            // Stalled: hold everything, but do not lose the interrupt.
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VEC;
            epc_q     <= '0;
            pending_q <= 1'b0;
            irq_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            pending_q <= pending_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    assign pc_out     = pc_q;
    assign epc_out    = epc_q;
    assign in_handler = (state_q == ST_HANDLER);
    assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed vector table plus hand-written async-reset sequences.
// Latency: expects each vector's results one clock after it is applied.
// Backpressure: exercises en=0 stalls with dropped redirects/int_end and latched irq.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        irq;
    logic        int_end;
    logic [1:0]  redir_valid;
    logic [63:0] redir_target;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic        in_handler;
    logic        irq_ack;

    int n_tests;
    int n_fail;

    pc_unit #(
        .WIDTH       (32),
        .RESET_VEC   (32'h0000_3000),
        .HANDLER_VEC (32'h0000_4180),
        .INC         (4),
        .NUM_REDIR   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .irq          (irq),
        .int_end      (int_end),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .pc_out       (pc_out),
        .epc_out      (epc_out),
        .in_handler   (in_handler),
        .irq_ack      (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        irq;
        logic        int_end;
        logic [1:0]  rv;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        h;
        logic        ack;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic i, input logic ie, input logic [1:0] rv,
                       input logic [31:0] t0, input logic [31:0] t1,
                       input logic [31:0] pc, input logic [31:0] epc,
                       input logic h, input logic ack);
        vec_t v;
        v.en = e; v.irq = i; v.int_end = ie; v.rv = rv; v.t0 = t0; v.t1 = t1;
        v.pc = pc; v.epc = epc; v.h = h; v.ack = ack;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                           input logic h, input logic ack);
        chk({tag, ".pc"},         pc_out,            pc);
        chk({tag, ".epc"},        epc_out,           epc);
        chk({tag, ".in_handler"}, {31'd0, in_handler}, {31'd0, h});
        chk({tag, ".irq_ack"},    {31'd0, irq_ack},    {31'd0, ack});
    endtask

    task automatic idle_inputs();
        en = 1'b0; irq = 1'b0; int_end = 1'b0; redir_valid = 2'b00; redir_target = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle_inputs();

        //   en irq ie  rv     t0             t1             pc             epc            h  ack
        // sequential fetch
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_3004, 32'h0,         0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_3008, 32'h0,         0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_300C, 32'h0,         0, 0);
        // redirect priority
        add(1, 0, 0, 2'b01, 32'h0000_3010, 32'h0,         32'h0000_3010, 32'h0,         0, 0);
        add(1, 0, 0, 2'b11, 32'h0000_3100, 32'h0000_3200, 32'h0000_3100, 32'h0,         0, 0);
        add(1, 0, 0, 2'b10, 32'h0000_3100, 32'h0000_3200, 32'h0000_3200, 32'h0,         0, 0);
        add(1, 0, 0, 2'b01, 32'h0000_3020, 32'h0,         32'h0000_3020, 32'h0,         0, 0);
        // interrupt entry, two handler cycles, return
        add(1, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4180, 32'h0000_3024, 1, 1);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4184, 32'h0000_3024, 1, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4188, 32'h0000_3024, 1, 0);
        add(1, 0, 1, 2'b00, 32'h0,         32'h0,         32'h0000_3024, 32'h0000_3024, 0, 0);
        // irq during stall is latched and taken when en rises
        add(1, 0, 0, 2'b01, 32'h0000_3040, 32'h0,         32'h0000_3040, 32'h0000_3024, 0, 0);
        add(0, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0000_3040, 32'h0000_3024, 0, 0);
        add(0, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_3040, 32'h0000_3024, 0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4180, 32'h0000_3044, 1, 1);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4184, 32'h0000_3044, 1, 0);
        // irq inside handler: no nesting, taken after return with epc re-saved
        add(1, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4188, 32'h0000_3044, 1, 0);
        add(1, 0, 1, 2'b00, 32'h0,         32'h0,         32'h0000_3044, 32'h0000_3044, 0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4180, 32'h0000_3048, 1, 1);
        add(1, 0, 1, 2'b00, 32'h0,         32'h0,         32'h0000_3048, 32'h0000_3048, 0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_304C, 32'h0000_3048, 0, 0);
        // int_end ignored in RUN; redirect dropped during stall
        add(1, 0, 1, 2'b00, 32'h0,         32'h0,         32'h0000_3050, 32'h0000_3048, 0, 0);
        add(0, 0, 0, 2'b01, 32'h0000_5000, 32'h0,         32'h0000_3050, 32'h0000_3048, 0, 0);
        // wrap-around
        add(1, 0, 0, 2'b01, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'h0000_3048, 0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_3048, 0, 0);
        add(0, 0, 1, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_3048, 0, 0);
        // several stalled irqs collapse into one entry
        add(0, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_3048, 0, 0);
        add(0, 1, 0, 2'b00, 32'h0,         32'h0,         32'h0000_0000, 32'h0000_3048, 0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_4180, 32'h0000_0004, 1, 1);
        add(1, 0, 1, 2'b00, 32'h0,         32'h0,         32'h0000_0004, 32'h0000_0004, 0, 0);
        add(1, 0, 0, 2'b00, 32'h0,         32'h0,         32'h0000_0008, 32'h0000_0004, 0, 0);

        // Reset state, including across a clock edge while rst is held.
        #2;
        chk_all("reset", 32'h0000_3000, 32'h0, 1'b0, 1'b0);
        en = 1'b1;
        @(posedge clk); #1;
        chk_all("reset_hold", 32'h0000_3000, 32'h0, 1'b0, 1'b0);
        en = 1'b0;
        rst = 1'b0;

        foreach (vecs[k]) begin
            en           = vecs[k].en;
            irq          = vecs[k].irq;
            int_end      = vecs[k].int_end;
            redir_valid  = vecs[k].rv;
            redir_target = {vecs[k].t1, vecs[k].t0};
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", k), vecs[k].pc, vecs[k].epc, vecs[k].h, vecs[k].ack);
        end

        // Async reset in the middle of the handler takes effect before the next edge.
        idle_inputs();
        en = 1'b1; irq = 1'b1;
        @(posedge clk); #1;
        chk_all("pre_rst_entry", 32'h0000_4180, 32'h0000_000C, 1'b1, 1'b1);
        irq = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_mid_handler", 32'h0000_3000, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Async reset clears a latched irq: no entry after release.
        en = 1'b0; irq = 1'b1;
        @(posedge clk); #1;
        irq = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        en = 1'b1;
        @(posedge clk); #1;
        chk_all("rst_clears_pending", 32'h0000_3004, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
